// File: rtl/lsq_v2.sv
// lsq_v2: in-order load/store queue with tag-checked address fill, commit-gated stores and CDB broadcast.
// Ports:
//   clock, reset                       single clock, synchronous active-high reset
//   dp_valid/is_store/tag/dest         dispatch request; dp_ready, dp_idx report space and the next slot
//   ex_valid/idx/tag/addr/data/size    address/data fill for a waiting entry
//   commit_store, squash               ROB retirement of the head store, pipeline flush
//   dc_req_*                           dcache request from the head entry
//   dc_resp_done, dc_resp_data         dcache completion
//   cdb_*                              registered completion broadcast
//   count                              occupied entries
// Config: define LSQ_STORE_CDB_EN to also broadcast store completions (value 0) on the CDB.
module lsq_v2 #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     dp_valid,
    input  logic                     dp_is_store,
    input  logic [TAG_W-1:0]         dp_tag,
    input  logic [4:0]               dp_dest,
    output logic                     dp_ready,
    output logic [$clog2(DEPTH)-1:0] dp_idx,
    input  logic                     ex_valid,
    input  logic [$clog2(DEPTH)-1:0] ex_idx,
    input  logic [TAG_W-1:0]         ex_tag,
    input  logic [31:0]              ex_addr,
    input  logic [31:0]              ex_data,
    input  logic [1:0]               ex_size,
    input  logic                     commit_store,
    input  logic                     squash,
    output logic                     dc_req_valid,
    output logic [31:0]              dc_req_addr,
    output logic [31:0]              dc_req_data,
    output logic [1:0]               dc_req_size,
    output logic                     dc_req_store,
    input  logic                     dc_resp_done,
    input  logic [31:0]              dc_resp_data,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [31:0]              cdb_value,
    output logic [4:0]               cdb_dest,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int IW = $clog2(DEPTH);
`ifdef LSQ_STORE_CDB_EN
    localparam bit STORE_CDB = 1'b1;
`else
    localparam bit STORE_CDB = 1'b0;
`endif
    typedef enum logic [1:0] {EMPTY, WAIT_ADDR, READY, ISSUED} st_t;
    st_t               st       [DEPTH];
    logic              committed[DEPTH];
    logic              is_store [DEPTH];
    logic [TAG_W-1:0]  tag      [DEPTH];
    logic [4:0]        dest     [DEPTH];
    logic [31:0]       addr     [DEPTH];
    logic [31:0]       data     [DEPTH];
    logic [1:0]        size     [DEPTH];
    logic [IW-1:0]     head, tail;
    logic              alloc, fill, commit, issue, keep, deq, bcast;
    always_comb begin
        dp_ready     = count != (IW+1)'(DEPTH);
        dp_idx       = tail;
        alloc        = dp_valid && dp_ready && !squash;
        fill         = ex_valid && !squash && st[ex_idx] == WAIT_ADDR && tag[ex_idx] == ex_tag;
        commit       = commit_store && !squash && st[head] != EMPTY && is_store[head];
        issue        = st[head] == READY && (!is_store[head] || committed[head]);
        // only a committed store at head survives a flush
        keep         = st[head] != EMPTY && is_store[head] && committed[head];
        deq          = dc_resp_done && st[head] == ISSUED && (!squash || keep);
        bcast        = deq && (!is_store[head] || STORE_CDB);
        dc_req_valid = issue || st[head] == ISSUED;
        dc_req_addr  = addr[head];
        dc_req_data  = data[head];
        dc_req_size  = size[head];
        dc_req_store = is_store[head];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                st[i]        <= EMPTY;
                committed[i] <= 1'b0;
            end
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_dest  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && !(keep && head == IW'(i))) begin
                    st[i]        <= EMPTY;
                    committed[i] <= 1'b0;
                end else if (alloc && tail == IW'(i)) begin
                    st[i]        <= WAIT_ADDR;
                    committed[i] <= 1'b0;
                    is_store[i]  <= dp_is_store;
                    tag[i]       <= dp_tag;
                    dest[i]      <= dp_dest;
                end else begin
                    if (fill && ex_idx == IW'(i)) begin
                        st[i]   <= READY;
                        addr[i] <= ex_addr;
                        data[i] <= ex_data;
                        size[i] <= ex_size;
                    end else if (deq && head == IW'(i)) begin
                        st[i] <= EMPTY;
                    end else if (issue && head == IW'(i)) begin
                        st[i] <= ISSUED;
                    end
                    if (commit && head == IW'(i))
                        committed[i] <= 1'b1;
                end
            end
            head <= head + IW'(deq);
            if (squash) begin
                tail  <= keep ? head + IW'(1) : head;
                count <= (keep && !deq) ? (IW+1)'(1) : '0;
            end else begin
                tail  <= tail + IW'(alloc);
                count <= count + (IW+1)'(alloc) - (IW+1)'(deq);
            end
            cdb_valid <= bcast;
            if (bcast) begin
                cdb_tag   <= tag[head];
                cdb_dest  <= dest[head];
                cdb_value <= is_store[head] ? 32'd0 : dc_resp_data;
            end
        end
    end
endmodule

// File: tb/tb_lsq_v2.sv
// tb_lsq_v2: directed scenarios plus randomized traffic against a queue-level reference model of lsq_v2.
module tb_lsq_v2;
`ifdef LSQ_STORE_CDB_EN
    localparam bit STORE_CDB = 1'b1;
`else
    localparam bit STORE_CDB = 1'b0;
`endif
    logic        clock = 0, reset = 0;
    logic        dp_valid, dp_is_store, dp_ready;
    logic [4:0]  dp_tag, dp_dest;
    logic [2:0]  dp_idx;
    logic        ex_valid;
    logic [2:0]  ex_idx;
    logic [4:0]  ex_tag;
    logic [31:0] ex_addr, ex_data;
    logic [1:0]  ex_size;
    logic        commit_store, squash;
    logic        dc_req_valid, dc_req_store;
    logic [31:0] dc_req_addr, dc_req_data;
    logic [1:0]  dc_req_size;
    logic        dc_resp_done;
    logic [31:0] dc_resp_data;
    logic        cdb_valid;
    logic [4:0]  cdb_tag, cdb_dest;
    logic [31:0] cdb_value;
    logic [3:0]  count;
    int checks = 0, errors = 0;

    lsq_v2 dut (
        .clock(clock), .reset(reset),
        .dp_valid(dp_valid), .dp_is_store(dp_is_store), .dp_tag(dp_tag), .dp_dest(dp_dest),
        .dp_ready(dp_ready), .dp_idx(dp_idx),
        .ex_valid(ex_valid), .ex_idx(ex_idx), .ex_tag(ex_tag), .ex_addr(ex_addr),
        .ex_data(ex_data), .ex_size(ex_size),
        .commit_store(commit_store), .squash(squash),
        .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data),
        .dc_req_size(dc_req_size), .dc_req_store(dc_req_store),
        .dc_resp_done(dc_resp_done), .dc_resp_data(dc_resp_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_dest(cdb_dest),
        .count(count)
    );

    always #5 clock = ~clock;

    // reference model: the queue holds live entries oldest first; mhead is the slot of q[0]
    typedef struct {
        bit          st;
        logic [4:0]  tag, dest;
        bit          filled, committed, issued;
        logic [31:0] addr, data;
        logic [1:0]  size;
    } ent_t;
    ent_t q[$];
    int mhead;
    bit ecv;
    logic [4:0]  etag, edest;
    logic [31:0] eval;

    task automatic model_step();
        bit ready_pre = q.size() < 8;
        bit done = q.size() > 0 && q[0].issued && dc_resp_done;
        bit issue_now = q.size() > 0 && q[0].filled && !q[0].issued && (!q[0].st || q[0].committed);
        ecv = 0;
        if (squash) begin
            bit keep = q.size() > 0 && q[0].st && q[0].committed;
            if (!keep) q.delete();
            else begin
                while (q.size() > 1) void'(q.pop_back());
                if (done) begin
                    ecv = STORE_CDB; etag = q[0].tag; edest = q[0].dest; eval = 0;
                    void'(q.pop_front()); mhead = (mhead + 1) % 8;
                end else if (issue_now) q[0].issued = 1;
            end
        end else begin
            if (commit_store && q.size() > 0 && q[0].st) q[0].committed = 1;
            if (ex_valid) begin
                int p = (int'(ex_idx) - mhead + 8) % 8;
                if (p < q.size() && !q[p].filled && q[p].tag == ex_tag) begin
                    q[p].filled = 1; q[p].addr = ex_addr; q[p].data = ex_data; q[p].size = ex_size;
                end
            end
            if (done) begin
                ecv = !q[0].st || STORE_CDB; etag = q[0].tag; edest = q[0].dest;
                eval = q[0].st ? 32'd0 : dc_resp_data;
                void'(q.pop_front()); mhead = (mhead + 1) % 8;
            end else if (issue_now) q[0].issued = 1;
            if (dp_valid && ready_pre) begin
                ent_t e;
                e.st = dp_is_store; e.tag = dp_tag; e.dest = dp_dest;
                e.filled = 0; e.committed = 0; e.issued = 0;
                e.addr = 0; e.data = 0; e.size = 0;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle();
        dp_valid = 0; dp_is_store = 0; dp_tag = 0; dp_dest = 0;
        ex_valid = 0; ex_idx = 0; ex_tag = 0; ex_addr = 0; ex_data = 0; ex_size = 0;
        commit_store = 0; squash = 0; dc_resp_done = 0; dc_resp_data = 0;
    endtask

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); reset = 0;
        q.delete(); mhead = 0; ecv = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dp_ready !== 1'b1) begin errors++; $display("FAIL reset_dp_ready got %b want 1", dp_ready); end
        checks++; if (dp_idx !== 3'd0) begin errors++; $display("FAIL reset_dp_idx got %0d want 0", dp_idx); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL reset_dc_req_valid got %b want 0", dc_req_valid); end
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_cdb_valid got %b want 0", cdb_valid); end
        checks++; if ({cdb_tag, cdb_dest, cdb_value} !== 42'd0) begin errors++; $display("FAIL reset_cdb_fields got %h/%h/%h want 0", cdb_tag, cdb_dest, cdb_value); end
    endtask

    task automatic test_fill_and_load();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            checks++; if (dp_idx !== 3'(i)) begin errors++; $display("FAIL fill_dp_idx got %0d want %0d", dp_idx, i); end
            dp_valid = 1; dp_tag = 5'(i); dp_dest = 5'(i + 8); tick();
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", count); end
        checks++; if (dp_ready !== 1'b0) begin errors++; $display("FAIL full_dp_ready got %b want 0", dp_ready); end
        dp_tag = 5'd20; tick();
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ninth_count got %0d want 8", count); end
        dp_valid = 0;
        ex_valid = 1; ex_idx = 0; ex_tag = 0; ex_addr = 32'h100; tick(); ex_valid = 0;
        checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 32'h100) begin errors++; $display("FAIL load_req got %b/%h want 1/00000100", dc_req_valid, dc_req_addr); end
        tick();
        checks++; if (dc_req_valid !== 1'b1) begin errors++; $display("FAIL load_issued_valid got %b want 1", dc_req_valid); end
        dc_resp_done = 1; dc_resp_data = 32'hDEADBEEF; tick(); dc_resp_done = 0;
        checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd0 || cdb_dest !== 5'd8 || cdb_value !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_cdb got %b/%h/%h/%h want 1/00/08/deadbeef", cdb_valid, cdb_tag, cdb_dest, cdb_value); end
        checks++; if (count !== 4'd7 || dp_ready !== 1'b1 || dp_idx !== 3'd0) begin errors++; $display("FAIL after_deq got cnt %0d rdy %b idx %0d want 7/1/0", count, dp_ready, dp_idx); end
        tick();
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL cdb_single_pulse got %b want 0", cdb_valid); end
    endtask

    task automatic test_store_commit();
        do_reset();
        dp_valid = 1; dp_is_store = 1; dp_tag = 3; dp_dest = 4; tick(); idle();
        ex_valid = 1; ex_idx = 0; ex_tag = 3; ex_addr = 32'h200; ex_data = 32'h55; ex_size = 2; tick(); idle();
        for (int i = 0; i < 3; i++) begin
            checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL store_uncommitted got %b want 0", dc_req_valid); end
            tick();
        end
        commit_store = 1; tick(); commit_store = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 32'h200 || dc_req_data !== 32'h55 || dc_req_size !== 2'd2 || dc_req_store !== 1'b1) begin
                errors++; $display("FAIL store_req got %b/%h/%h/%0d/%b want 1/200/55/2/1", dc_req_valid, dc_req_addr, dc_req_data, dc_req_size, dc_req_store); end
            tick();
        end
        dc_resp_done = 1; tick(); dc_resp_done = 0;
        checks++; if (cdb_valid !== STORE_CDB) begin errors++; $display("FAIL store_cdb got %b want %b", cdb_valid, STORE_CDB); end
        checks++; if (count !== 4'd0 || dc_req_valid !== 1'b0) begin errors++; $display("FAIL store_done got cnt %0d v %b want 0/0", count, dc_req_valid); end
    endtask

    task automatic test_bad_fill();
        do_reset();
        dp_valid = 1; dp_tag = 5; dp_dest = 1; tick();
        dp_tag = 7; dp_dest = 2; tick(); idle();
        ex_valid = 1; ex_idx = 1; ex_tag = 7; ex_addr = 32'h500; tick();
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL waiting_head got %b want 0", dc_req_valid); end
        ex_addr = 32'h600; tick();
        ex_idx = 0; ex_tag = 6; ex_addr = 32'h700; tick();
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL wrong_tag got %b want 0", dc_req_valid); end
        ex_tag = 5; ex_addr = 32'h300; tick(); idle();
        checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 32'h300) begin errors++; $display("FAIL good_fill got %b/%h want 1/300", dc_req_valid, dc_req_addr); end
        tick();
        dc_resp_done = 1; dc_resp_data = 32'h1; tick(); dc_resp_done = 0;
        checks++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd5) begin errors++; $display("FAIL bad_fill_cdb got %b/%h want 1/05", cdb_valid, cdb_tag); end
        checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 32'h500) begin errors++; $display("FAIL refill_dropped got %b/%h want 1/500", dc_req_valid, dc_req_addr); end
    endtask

    task automatic test_squash();
        do_reset();
        dp_valid = 1; dp_is_store = 1; dp_tag = 1; tick(); idle();
        ex_valid = 1; ex_idx = 0; ex_tag = 1; ex_addr = 32'h900; tick(); idle();
        commit_store = 1; dp_valid = 1; dp_tag = 2; tick(); commit_store = 0;
        dp_tag = 3; tick();
        dp_tag = 4; tick();
        checks++; if (count !== 4'd4 || dc_req_valid !== 1'b1) begin errors++; $display("FAIL pre_squash got cnt %0d v %b want 4/1", count, dc_req_valid); end
        squash = 1; dp_tag = 9; ex_valid = 1; ex_idx = 1; ex_tag = 2; tick(); idle();
        checks++; if (count !== 4'd1 || dp_idx !== 3'd1) begin errors++; $display("FAIL post_squash got cnt %0d idx %0d want 1/1", count, dp_idx); end
        checks++; if (dc_req_valid !== 1'b1 || dc_req_addr !== 32'h900) begin errors++; $display("FAIL kept_store got %b/%h want 1/900", dc_req_valid, dc_req_addr); end
        dc_resp_done = 1; tick(); dc_resp_done = 0;
        checks++; if (count !== 4'd0 || cdb_valid !== STORE_CDB) begin errors++; $display("FAIL squash_done got cnt %0d cdb %b want 0/%b", count, cdb_valid, STORE_CDB); end
    endtask

    task automatic test_full_deq();
        do_reset();
        for (int i = 0; i < 8; i++) begin dp_valid = 1; dp_tag = 5'(i); tick(); end
        idle();
        ex_valid = 1; ex_idx = 0; ex_tag = 0; tick(); idle();
        tick();
        dp_valid = 1; dp_tag = 5'd17; dc_resp_done = 1; tick(); idle();
        checks++; if (count !== 4'd7 || dp_idx !== 3'd0) begin errors++; $display("FAIL full_deq got cnt %0d idx %0d want 7/0", count, dp_idx); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        dp_valid = 1; dp_tag = 2; tick(); idle();
        ex_valid = 1; ex_idx = 0; ex_tag = 2; tick(); idle();
        tick();
        reset = 1; tick(); reset = 0;
        dc_resp_done = 1; tick(); dc_resp_done = 0;
        checks++; if (cdb_valid !== 1'b0 || count !== 4'd0 || dc_req_valid !== 1'b0) begin
            errors++; $display("FAIL midflight got cdb %b cnt %0d v %b want 0/0/0", cdb_valid, count, dc_req_valid); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            bit ev;
            dp_valid = $urandom_range(0, 99) < 50; dp_is_store = $urandom_range(0, 1) == 1;
            dp_tag = 5'($urandom); dp_dest = 5'($urandom);
            ex_valid = $urandom_range(0, 99) < 60;
            if (q.size() > 0 && $urandom_range(0, 99) < 80) begin
                int k = $urandom_range(0, q.size() - 1);
                ex_idx = 3'((mhead + k) % 8);
                ex_tag = $urandom_range(0, 4) == 0 ? 5'($urandom) : q[k].tag;
            end else begin
                ex_idx = 3'($urandom); ex_tag = 5'($urandom);
            end
            ex_addr = $urandom; ex_data = $urandom; ex_size = 2'($urandom);
            commit_store = $urandom_range(0, 99) < 30;
            dc_resp_done = $urandom_range(0, 99) < 40; dc_resp_data = $urandom;
            squash = $urandom_range(0, 99) < 2;
            model_step();
            tick();
            checks++; if (count !== 4'(q.size()) || dp_ready !== (q.size() < 8) || dp_idx !== 3'((mhead + q.size()) % 8)) begin
                errors++; $display("FAIL rnd_occupancy cyc %0d got cnt %0d rdy %b idx %0d want %0d/%b/%0d", n, count, dp_ready, dp_idx, q.size(), q.size() < 8, (mhead + q.size()) % 8); end
            ev = q.size() > 0 && (q[0].issued || (q[0].filled && (!q[0].st || q[0].committed)));
            checks++; if (dc_req_valid !== ev) begin errors++; $display("FAIL rnd_req_valid cyc %0d got %b want %b", n, dc_req_valid, ev); end
            else if (ev && (dc_req_addr !== q[0].addr || dc_req_data !== q[0].data || dc_req_size !== q[0].size || dc_req_store !== q[0].st)) begin
                errors++; $display("FAIL rnd_req_fields cyc %0d got %h/%h/%0d/%b want %h/%h/%0d/%b", n, dc_req_addr, dc_req_data, dc_req_size, dc_req_store, q[0].addr, q[0].data, q[0].size, q[0].st); end
            checks++; if (cdb_valid !== ecv) begin errors++; $display("FAIL rnd_cdb_valid cyc %0d got %b want %b", n, cdb_valid, ecv); end
            else if (ecv && (cdb_tag !== etag || cdb_dest !== edest || cdb_value !== eval)) begin
                errors++; $display("FAIL rnd_cdb_fields cyc %0d got %h/%h/%h want %h/%h/%h", n, cdb_tag, cdb_dest, cdb_value, etag, edest, eval); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_fill_and_load();
        test_store_commit();
        test_bad_fill();
        test_squash();
        test_full_deq();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
